// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer (IDLE/RUN/DONE) feeding the branch-target LUT.
// All outputs are registered except lut_addr; a taken branch lands on prog_ctr one cycle later.
module pc_fetch_ctrl #(
  parameter int D  = 12,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [D-1:0]  start_addr,
  input  logic          stall,
  input  logic          branch_en,
  input  logic          branch_cond,
  input  logic [4:0]    branch_idx,
  input  logic          halt,
  output logic [4:0]    lut_addr,
  input  logic [D-1:0]  lut_target,
  output logic [D-1:0]  prog_ctr,
  output logic          busy,
  output logic          done,
  output logic [1:0]    fault,
  output logic [CW-1:0] cycle_cnt,
  output logic [CW-1:0] instr_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] FLT_HALT     = 2'd0;
  localparam logic [1:0] FLT_UNMAPPED = 2'd1;
  localparam logic [1:0] FLT_OVERFLOW = 2'd2;

  localparam logic [D-1:0]  PC_ONE  = {{(D-1){1'b0}}, 1'b1};
  localparam logic [D-1:0]  PC_MAX  = {D{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t        state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [1:0]    fault_q, fault_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [CW-1:0] ins_q, ins_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  assign lut_addr = branch_idx;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    cyc_d   = cyc_q;
    ins_d   = ins_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = start_addr;
          fault_d = FLT_HALT;
          cyc_d   = '0;
          ins_d   = '0;
        end
      end
      S_RUN: begin
        cyc_d = (cyc_q == CNT_MAX) ? cyc_q : cyc_q + CNT_ONE;
        // A stalled cycle neither retires nor looks at halt/branch.
        if (!stall) begin
          ins_d = (ins_q == CNT_MAX) ? ins_q : ins_q + CNT_ONE;
          if (halt) begin
            state_d = S_DONE;
            fault_d = FLT_HALT;
          end else if (branch_en && branch_cond) begin
            if (lut_target != '0) begin
              pc_d = lut_target;
            end else begin
              state_d = S_DONE;
              fault_d = FLT_UNMAPPED;
            end
          end else if (pc_q == PC_MAX) begin
            state_d = S_DONE;
            fault_d = FLT_OVERFLOW;
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      fault_q <= FLT_HALT;
      cyc_q   <= '0;
      ins_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign prog_ctr  = pc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;

endmodule
